mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_if.sv | 29 ++
 rtl/mem_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Cache-side request bus and SRAM-side access bus of mem_ctrl.
// slave is the controller's view, master the view of the cache/SRAM environment.
interface mem_ctrl_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int AW         = 12
);
   logic                  mem_valid_i;
   logic                  mem_we_i;
   logic [ADDR_WIDTH-1:0] mem_adr_i;
   logic [DATA_WIDTH-1:0] mem_wdata_i;
   logic                  mem_ready_o;
   logic [DATA_WIDTH-1:0] mem_rdata_o;
   logic                  sram_en_o;
   logic                  sram_we_o;
   logic [AW-1:0]         sram_adr_o;
   logic [DATA_WIDTH-1:0] sram_wdata_o;
   logic [DATA_WIDTH-1:0] sram_rdata_i;

   modport slave (
      input  mem_valid_i, mem_we_i, mem_adr_i, mem_wdata_i, sram_rdata_i,
      output mem_ready_o, mem_rdata_o, sram_en_o, sram_we_o, sram_adr_o, sram_wdata_o
   );

   modport master (
      output mem_valid_i, mem_we_i, mem_adr_i, mem_wdata_i, sram_rdata_i,
      input  mem_ready_o, mem_rdata_o, sram_en_o, sram_we_o, sram_adr_o, sram_wdata_o
   );
endinterface

// File: rtl/mem_ctrl.sv
// Single-request cache-to-SRAM controller with programmable wait latency.
// Optional MEM_CTRL_STATS_EN adds saturating read/write/out-of-range counters.
module mem_ctrl #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 4096,
   parameter int LATENCY    = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   mem_ctrl_if.slave   bus
`ifdef MEM_CTRL_STATS_EN
   ,
   output logic [15:0] rd_cnt_o,
   output logic [15:0] wr_cnt_o,
   output logic [15:0] oor_cnt_o
`endif
);
   // state   | meaning
   // IDLE    | waiting for mem_valid_i
   // WAIT    | counting down LATENCY wait cycles
   // ACCESS  | SRAM strobe issued
   // CAPTURE | SRAM read data in flight
   // RESP    | completion pulse issued
   // HOLD    | waiting for mem_valid_i to drop
   localparam int AW = $clog2(MEM_WORDS);
   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_WORDS);

   typedef enum logic [2:0] {IDLE, WAIT, ACCESS, CAPTURE, RESP, HOLD} state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  oor;

   logic                  ready_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  sram_en_q;
   logic                  sram_we_q;
   logic [AW-1:0]         sram_adr_q;
   logic [DATA_WIDTH-1:0] sram_wdata_q;

   assign oor = {1'b0, adr_q} >= DEPTH;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      adr_d   = adr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (bus.mem_valid_i) begin
               we_d    = bus.mem_we_i;
               adr_d   = bus.mem_adr_i;
               wdata_d = bus.mem_wdata_i;
               cnt_d   = 4'(LATENCY);
               state_d = (LATENCY == 0) ? ACCESS : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = ACCESS;
         end
         ACCESS:  state_d = CAPTURE;
         CAPTURE: state_d = RESP;
         RESP:    state_d = HOLD;
         HOLD: begin
            if (!bus.mem_valid_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the current state, so each state's effect
   // appears on the pins one cycle after that state is entered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         adr_q        <= '0;
         wdata_q      <= '0;
         ready_q      <= 1'b0;
         rdata_q      <= '0;
         sram_en_q    <= 1'b0;
         sram_we_q    <= 1'b0;
         sram_adr_q   <= '0;
         sram_wdata_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         wdata_q   <= wdata_d;
         ready_q   <= (state_q == RESP);
         sram_en_q <= (state_q == ACCESS) && !oor;
         sram_we_q <= (state_q == ACCESS) && !oor && we_q;
         if (state_q == ACCESS) begin
            sram_adr_q   <= adr_q[AW-1:0];
            sram_wdata_q <= wdata_q;
         end
         if ((state_q == RESP) && !we_q) rdata_q <= oor ? '0 : bus.sram_rdata_i;
      end
   end

   assign bus.mem_ready_o  = ready_q;
   assign bus.mem_rdata_o  = rdata_q;
   assign bus.sram_en_o    = sram_en_q;
   assign bus.sram_we_o    = sram_we_q;
   assign bus.sram_adr_o   = sram_adr_q;
   assign bus.sram_wdata_o = sram_wdata_q;

`ifdef MEM_CTRL_STATS_EN
   logic [15:0] rd_cnt_q, wr_cnt_q, oor_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         oor_cnt_q <= '0;
      end else if (state_q == RESP) begin
         if (oor) begin
            if (oor_cnt_q != 16'hFFFF) oor_cnt_q <= oor_cnt_q + 16'd1;
         end else if (we_q) begin
            if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
         end else begin
            if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
         end
      end
   end

   assign rd_cnt_o  = rd_cnt_q;
   assign wr_cnt_o  = wr_cnt_q;
   assign oor_cnt_o = oor_cnt_q;
`endif
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: LATENCY=3 and LATENCY=0 instances driven with the same
// request stream, each backed by its own SRAM model, checked against a word-array reference.
module tb_mem_ctrl;
   logic clk;
   logic rst;
   logic clr;
   int   tests = 0;
   int   fails = 0;
   int   edge_cnt = 0;

   mem_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .AW(12)) b3 ();
   mem_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .AW(12)) b0 ();

`ifdef MEM_CTRL_STATS_EN
   logic [15:0] rd3, wr3, oor3, rd0, wr0, oor0;
`endif

   mem_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_WORDS(4096), .LATENCY(3)) dut3 (
      .clk_i(clk), .rst_i(rst), .bus(b3)
`ifdef MEM_CTRL_STATS_EN
      , .rd_cnt_o(rd3), .wr_cnt_o(wr3), .oor_cnt_o(oor3)
`endif
   );

   mem_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_WORDS(4096), .LATENCY(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .bus(b0)
`ifdef MEM_CTRL_STATS_EN
      , .rd_cnt_o(rd0), .wr_cnt_o(wr0), .oor_cnt_o(oor0)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   logic [31:0] sram3 [4096];
   logic [31:0] sram0 [4096];

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 4096; i++) sram3[i] <= '0;
         b3.sram_rdata_i <= '0;
      end else if (b3.sram_en_o) begin
         if (b3.sram_we_o) sram3[b3.sram_adr_o] <= b3.sram_wdata_o;
         b3.sram_rdata_i <= sram3[b3.sram_adr_o];
      end
   end

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 4096; i++) sram0[i] <= '0;
         b0.sram_rdata_i <= '0;
      end else if (b0.sram_en_o) begin
         if (b0.sram_we_o) sram0[b0.sram_adr_o] <= b0.sram_wdata_o;
         b0.sram_rdata_i <= sram0[b0.sram_adr_o];
      end
   end

   int          en_cnt3 = 0, en_edge3 = 0, rdy_cnt3 = 0, rdy_edge3 = 0;
   int          en_cnt0 = 0, en_edge0 = 0, rdy_cnt0 = 0, rdy_edge0 = 0;
   logic [11:0] en_adr3, en_adr0;
   logic        en_we3, en_we0;
   logic [31:0] en_wd3, en_wd0, rdy_data3, rdy_data0;

   always @(negedge clk) begin
      if (b3.sram_en_o) begin
         en_cnt3  <= en_cnt3 + 1;
         en_edge3 <= edge_cnt;
         en_adr3  <= b3.sram_adr_o;
         en_we3   <= b3.sram_we_o;
         en_wd3   <= b3.sram_wdata_o;
      end
      if (b3.mem_ready_o) begin
         rdy_cnt3  <= rdy_cnt3 + 1;
         rdy_edge3 <= edge_cnt;
         rdy_data3 <= b3.mem_rdata_o;
      end
   end

   always @(negedge clk) begin
      if (b0.sram_en_o) begin
         en_cnt0  <= en_cnt0 + 1;
         en_edge0 <= edge_cnt;
         en_adr0  <= b0.sram_adr_o;
         en_we0   <= b0.sram_we_o;
         en_wd0   <= b0.sram_wdata_o;
      end
      if (b0.mem_ready_o) begin
         rdy_cnt0  <= rdy_cnt0 + 1;
         rdy_edge0 <= edge_cnt;
         rdy_data0 <= b0.mem_rdata_o;
      end
   end

   // reference model: memory contents, last delivered read data, response tallies
   logic [31:0] ref_mem [4096];
   logic [31:0] exp_rdata;
   int          rd_m, wr_m, oor_m;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic [15:0] adr, input logic [31:0] wd);
      b3.mem_valid_i = v;  b0.mem_valid_i = v;
      b3.mem_we_i    = we; b0.mem_we_i    = we;
      b3.mem_adr_i   = adr; b0.mem_adr_i  = adr;
      b3.mem_wdata_i = wd; b0.mem_wdata_i = wd;
   endtask

   task automatic txn(input logic we, input logic [15:0] adr, input logic [31:0] wd,
                      input int hold, input int drop_at);
      int   n, k, e3, e0, r3, r0;
      logic inr;
      inr = (adr < 16'd4096);
      e3 = en_cnt3; e0 = en_cnt0; r3 = rdy_cnt3; r0 = rdy_cnt0;
      @(negedge clk);
      drive(1'b1, we, adr, wd);
      n = edge_cnt + 1;
      k = 0;
      while (k < 40 && !((rdy_cnt3 != r3) && (rdy_cnt0 != r0) && (k >= hold))) begin
         @(negedge clk);
         k++;
         drive(!(drop_at != 0 && k >= drop_at), 1'($urandom), 16'($urandom), $urandom);
      end
      drive(1'b0, 1'($urandom), 16'($urandom), $urandom);
      repeat (4) @(negedge clk);

      if (!inr) oor_m++;
      else if (we) wr_m++;
      else rd_m++;
      if (we) begin
         if (inr) ref_mem[adr[11:0]] = wd;
      end else begin
         exp_rdata = inr ? ref_mem[adr[11:0]] : 32'h0;
      end

      chk("timeout", 64'(k < 40), 64'd1);
      chk("rdy_pulses_L3", 64'(rdy_cnt3 - r3), 64'd1);
      chk("rdy_pulses_L0", 64'(rdy_cnt0 - r0), 64'd1);
      chk("rdy_edge_L3", 64'(rdy_edge3), 64'(n + 6));
      chk("rdy_edge_L0", 64'(rdy_edge0), 64'(n + 3));
      chk("rdata_L3", 64'(rdy_data3), 64'(exp_rdata));
      chk("rdata_L0", 64'(rdy_data0), 64'(exp_rdata));
      chk("en_pulses_L3", 64'(en_cnt3 - e3), 64'(inr));
      chk("en_pulses_L0", 64'(en_cnt0 - e0), 64'(inr));
      if (inr) begin
         chk("en_edge_L3", 64'(en_edge3), 64'(n + 4));
         chk("en_edge_L0", 64'(en_edge0), 64'(n + 1));
         chk("en_adr_L3", 64'(en_adr3), 64'(adr[11:0]));
         chk("en_adr_L0", 64'(en_adr0), 64'(adr[11:0]));
         chk("en_we_L3", 64'(en_we3), 64'(we));
         chk("en_we_L0", 64'(en_we0), 64'(we));
         if (we) begin
            chk("en_wdata_L3", 64'(en_wd3), 64'(wd));
            chk("en_wdata_L0", 64'(en_wd0), 64'(wd));
         end
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ready"}, 64'({b3.mem_ready_o, b0.mem_ready_o}), 64'd0);
      chk({tag, "_rdata"}, 64'({b3.mem_rdata_o, b0.mem_rdata_o}), 64'd0);
      chk({tag, "_sram_en_we"}, 64'({b3.sram_en_o, b3.sram_we_o, b0.sram_en_o, b0.sram_we_o}), 64'd0);
      chk({tag, "_sram_adr"}, 64'({b3.sram_adr_o, b0.sram_adr_o}), 64'd0);
      chk({tag, "_sram_wdata"}, {b3.sram_wdata_o, b0.sram_wdata_o}, 64'd0);
   endtask

   task automatic mid_reset(input logic we, input logic [15:0] adr, input logic [31:0] wd);
      int e3, e0, r3, r0;
      e3 = en_cnt3; e0 = en_cnt0; r3 = rdy_cnt3; r0 = rdy_cnt0;
      @(negedge clk);
      drive(1'b1, we, adr, wd);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b0, 16'h0, 32'h0);
      chk_idle_outputs("midrst");
      repeat (12) @(negedge clk);
      chk("midrst_en_L3", 64'(en_cnt3 - e3), 64'd0);
      chk("midrst_en_L0", 64'(en_cnt0 - e0), 64'd0);
      chk("midrst_rdy_L3", 64'(rdy_cnt3 - r3), 64'd0);
      chk("midrst_rdy_L0", 64'(rdy_cnt0 - r0), 64'd0);
      exp_rdata = 32'h0;
      rd_m = 0; wr_m = 0; oor_m = 0;
   endtask

`ifdef MEM_CTRL_STATS_EN
   task automatic chk_stats(input string tag);
      chk({tag, "_rd_cnt"}, 64'({rd3, rd0}), 64'({16'(rd_m), 16'(rd_m)}));
      chk({tag, "_wr_cnt"}, 64'({wr3, wr0}), 64'({16'(wr_m), 16'(wr_m)}));
      chk({tag, "_oor_cnt"}, 64'({oor3, oor0}), 64'({16'(oor_m), 16'(oor_m)}));
   endtask
`endif

   initial begin
      logic [15:0] adr;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
      exp_rdata = 32'h0;
      rd_m = 0; wr_m = 0; oor_m = 0;
      rst = 1'b1;
      clr = 1'b1;
      drive(1'b0, 1'b0, 16'h0, 32'h0);
      repeat (3) @(negedge clk);
      clr = 1'b0;
      chk_idle_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      txn(1'b1, 16'h0010, 32'hDEADBEEF, 0, 0);
      txn(1'b0, 16'h0010, 32'h0, 0, 0);
      txn(1'b0, 16'h0010, 32'h0, 20, 0);
      txn(1'b1, 16'h2000, 32'h12345678, 0, 0);
      txn(1'b0, 16'h2000, 32'h0, 0, 0);
`ifdef MEM_CTRL_STATS_EN
      chk("oor_cnt_is_2_L3", 64'(oor3), 64'd2);
      chk_stats("after_oor");
`endif
      txn(1'b1, 16'h0020, 32'hBEEFDEAD, 0, 0);
      txn(1'b0, 16'h0020, 32'h0, 0, 0);
      txn(1'b0, 16'h0FFF, 32'h0, 0, 1);
      txn(1'b1, 16'h1000, 32'hCAFEF00D, 0, 2);

      mid_reset(1'b1, 16'h0010, 32'h55555555);
      txn(1'b0, 16'h0010, 32'h0, 0, 0);

      for (int t = 0; t < 30; t++) begin
         adr = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(4096, 65535))
                                           : 16'($urandom_range(0, 63));
         txn(1'($urandom), adr, $urandom, int'($urandom_range(0, 5)),
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
`ifdef MEM_CTRL_STATS_EN
      chk_stats("final");
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "global timeout");
   end
endmodule
